// File: rtl/vga_clkprog.sv
// Serial programming engine for a DCM_CLKGEN that sets the VGA pixel clock (M/D load, GO, lock handshake).
// Optional build macro VGA_CLKPROG_TIMEOUT_EN adds a watchdog on the three DCM handshake wait states.
module vga_clkprog #(
  parameter int CLKDIV  = 4,
  parameter int TIMEOUT = 1048575
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_m,
  input  logic [7:0] cmd_d,
  output logic       cmd_ready,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic       vga_progclk,
  output logic       vga_progdata,
  output logic       vga_progen,
  input  logic       vga_progdone,
  input  logic       vga_locked
);

  localparam int            CW        = (CLKDIV > 2) ? $clog2(CLKDIV) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(CLKDIV - 1);
  localparam logic [CW-1:0] SLOT_HALF = CW'(CLKDIV / 2);
  localparam logic [3:0]    BIT_LAST  = 4'd9;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LOADD    = 4'd1,
    GAP1     = 4'd2,
    LOADM    = 4'd3,
    GAP2     = 4'd4,
    GO       = 4'd5,
    WAITLO   = 4'd6,
    WAITHI   = 4'd7,
    WAITLOCK = 4'd8
  } state_t;

  state_t        state_r, state_s;
  logic [CW-1:0] slot_r, slot_s;
  logic [3:0]    bit_r, bit_s;
  logic [7:0]    m_r, d_r;
  logic          pd_meta_r, pd_sync_r, lk_meta_r, lk_sync_r;
  logic          cmd_ready_r, busy_r, done_r, done_s;
  logic          progclk_r, progen_r, progdata_r, en_s, data_s;
  logic          accept_s, slot_end_s, tmo_s;

  // Frame bit: start 1, load selector (0 = D, 1 = M), then the 8 value bits LSB first.
  function automatic logic frame_bit(input logic sel, input logic [7:0] val, input logic [3:0] idx);
    logic [2:0] pos;
    pos = 3'(idx - 4'd2);
    if (idx == 4'd0) begin
      frame_bit = 1'b1;
    end else if (idx == 4'd1) begin
      frame_bit = sel;
    end else begin
      frame_bit = val[pos];
    end
  endfunction

  assign accept_s   = cmd_valid & cmd_ready_r;
  assign slot_end_s = (slot_r == SLOT_LAST);

  // Next state, bit index within a load, and slot counter.
  always_comb begin
    state_s = state_r;
    bit_s   = bit_r;
    done_s  = 1'b0;
    slot_s  = slot_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_s = LOADD;
          bit_s   = 4'd0;
        end else begin
          state_s = IDLE;
        end
      end
      LOADD, LOADM: begin
        if (slot_end_s && (bit_r == BIT_LAST)) begin
          state_s = (state_r == LOADD) ? GAP1 : GAP2;
          bit_s   = 4'd0;
        end else if (slot_end_s) begin
          bit_s = bit_r + 4'd1;
        end else begin
          bit_s = bit_r;
        end
      end
      GAP1: begin
        if (slot_end_s) state_s = LOADM;
        else            state_s = GAP1;
      end
      GAP2: begin
        if (slot_end_s) state_s = GO;
        else            state_s = GAP2;
      end
      GO: begin
        if (slot_end_s) state_s = WAITLO;
        else            state_s = GO;
      end
      WAITLO: begin
        if (!pd_sync_r) state_s = WAITHI;
        else if (tmo_s) state_s = IDLE;
        else            state_s = WAITLO;
      end
      WAITHI: begin
        if (pd_sync_r)  state_s = WAITLOCK;
        else if (tmo_s) state_s = IDLE;
        else            state_s = WAITHI;
      end
      WAITLOCK: begin
        if (lk_sync_r) begin
          state_s = IDLE;
          done_s  = 1'b1;
        end else if (tmo_s) begin
          state_s = IDLE;
        end else begin
          state_s = WAITLOCK;
        end
      end
      default: begin
        state_s = IDLE;
        bit_s   = 4'd0;
      end
    endcase
    // The acceptance cycle is still IDLE, so slot 0 begins on the following cycle.
    if ((state_s == IDLE) || (state_r == IDLE)) begin
      slot_s = '0;
    end else if (slot_end_s) begin
      slot_s = '0;
    end else begin
      slot_s = slot_r + CW'(1);
    end
  end

  // Programming-port levels for the slot that starts next.
  always_comb begin
    en_s   = 1'b0;
    data_s = 1'b0;
    case (state_s)
      LOADD: begin
        en_s   = 1'b1;
        data_s = frame_bit(1'b0, d_r, bit_s);
      end
      LOADM: begin
        en_s   = 1'b1;
        data_s = frame_bit(1'b1, m_r, bit_s);
      end
      GO: begin
        en_s   = 1'b1;
        data_s = 1'b0;
      end
      default: begin
        en_s   = 1'b0;
        data_s = 1'b0;
      end
    endcase
  end

  // Main state, command capture, status synchronizers and registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_r     <= IDLE;
      slot_r      <= '0;
      bit_r       <= 4'd0;
      m_r         <= 8'd0;
      d_r         <= 8'd0;
      pd_meta_r   <= 1'b0;
      pd_sync_r   <= 1'b0;
      lk_meta_r   <= 1'b0;
      lk_sync_r   <= 1'b0;
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      progclk_r   <= 1'b0;
      progen_r    <= 1'b0;
      progdata_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      slot_r      <= slot_s;
      bit_r       <= bit_s;
      pd_meta_r   <= vga_progdone;
      pd_sync_r   <= pd_meta_r;
      lk_meta_r   <= vga_locked;
      lk_sync_r   <= lk_meta_r;
      cmd_ready_r <= (state_s == IDLE);
      busy_r      <= (state_s != IDLE);
      done_r      <= done_s;
      progclk_r   <= (slot_s >= SLOT_HALF);
      progen_r    <= en_s;
      progdata_r  <= data_s;
      if (accept_s) begin
        m_r <= cmd_m;
        d_r <= cmd_d;
      end else begin
        m_r <= m_r;
        d_r <= d_r;
      end
    end
  end

`ifdef VGA_CLKPROG_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wait_cnt_r;
  logic          error_r, in_wait_s;

  assign in_wait_s = (state_r == WAITLO) || (state_r == WAITHI) || (state_r == WAITLOCK);
  assign tmo_s     = in_wait_s && (wait_cnt_r == TW'(TIMEOUT - 1));

  // Watchdog restarts on every state change so each wait state gets the full budget.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      wait_cnt_r <= '0;
      error_r    <= 1'b0;
    end else begin
      if (state_s != state_r) wait_cnt_r <= '0;
      else if (in_wait_s)     wait_cnt_r <= wait_cnt_r + TW'(1);
      else                    wait_cnt_r <= wait_cnt_r;
      if (accept_s)                                  error_r <= 1'b0;
      else if (tmo_s && !done_s && state_s == IDLE)  error_r <= 1'b1;
      else                                           error_r <= error_r;
    end
  end

  assign error = error_r;
`else
  assign tmo_s = 1'b0;
  assign error = 1'b0;
`endif

  assign cmd_ready    = cmd_ready_r;
  assign busy         = busy_r;
  assign done         = done_r;
  assign vga_progclk  = progclk_r;
  assign vga_progen   = progen_r;
  assign vga_progdata = progdata_r;

endmodule

// File: doc/vga_clkprog.md
VGA_CLKPROG -- requirements
Module: vga_clkprog

Interface
REQ-001: Parameter CLKDIV, default 4, sys_clk cycles per PROGCLK period; even, >=2.
REQ-002: Parameter TIMEOUT, default 1048575, sys_clk cycles allowed in each wait state.
REQ-003: sys_clk  in  1  system clock; every register SHALL be clocked on its rising edge.
REQ-004: sys_rst  in  1  synchronous, active-high reset.
REQ-005: cmd_valid  in  1  request to program a new VGA frequency.
REQ-006: cmd_m  in  8  multiplier minus one (M-1).
REQ-007: cmd_d  in  8  divider minus one (D-1).
REQ-008: cmd_ready  out  1  high only in IDLE.
REQ-009: busy  out  1  high in every state except IDLE.
REQ-010: done  out  1  one-cycle pulse when the new frequency is locked.
REQ-011: error  out  1  sticky timeout flag.
REQ-012: vga_progclk, vga_progdata, vga_progen  out  1 each  DCM_CLKGEN programming port; all three registered.
REQ-013: vga_progdone, vga_locked  in  1 each  DCM status inputs.

Function
REQ-014: vga_progdone and vga_locked SHALL each pass through a 2-flop synchronizer before use.
REQ-015: The block SHALL accept a command on cmd_valid & cmd_ready and capture cmd_m/cmd_d in the same cycle.
REQ-016: A slot counter (0..CLKDIV-1) SHALL be held at 0 in IDLE and run freely otherwise.
REQ-017: vga_progclk SHALL be 0 for counts 0..CLKDIV/2-1 and 1 otherwise; vga_progen/vga_progdata SHALL change only when the count wraps to 0, one slot = one PROGCLK period.
REQ-018: The first slot SHALL start the cycle after acceptance.
REQ-019: States: IDLE, LOADD, GAP1, LOADM, GAP2, GO, WAITLO, WAITHI, WAITLOCK.
REQ-020: LOADD SHALL last 10 slots, progen=1, data 1, 0, then D-1 bits 0..7 LSB first.
REQ-021: GAP1 and GAP2 SHALL last 1 slot each, progen=0, data=0.
REQ-022: LOADM SHALL last 10 slots, progen=1, data 1, 1, then M-1 bits 0..7 LSB first.
REQ-023: GO SHALL last 1 slot, progen=1, data=0; after that, progen=0 and data=0.
REQ-024: WAITLO SHALL advance when synced progdone=0; WAITHI SHALL advance when synced progdone=1; WAITLOCK SHALL advance when synced locked=1.
REQ-025: On leaving WAITLOCK, the block SHALL pulse done and return to IDLE; cmd_ready SHALL rise the following cycle.
REQ-026: cmd_valid while busy SHALL be ignored and not queued.
REQ-027: error SHALL clear when the next command is accepted.
REQ-028: A transfer SHALL be 23 slots (23*CLKDIV sys_clk cycles) from acceptance to the end of GO.

Reset
REQ-029: sys_rst SHALL force IDLE, slot count 0, vga_progclk=0, vga_progen=0, vga_progdata=0, done=0, error=0, busy=0, and clear the synchronizers.
REQ-030: Reset mid-transfer SHALL abort immediately; progen low guarantees the DCM discards the partial load, and the next command SHALL start clean at LOADD.

Configuration
REQ-031: Macro VGA_CLKPROG_TIMEOUT_EN, when defined, SHALL add a counter cleared on entry to WAITLO, WAITHI, and WAITLOCK.
REQ-032: With VGA_CLKPROG_TIMEOUT_EN defined, reaching TIMEOUT SHALL set error, produce no done pulse, and return to IDLE.
REQ-033: Without VGA_CLKPROG_TIMEOUT_EN, the block SHALL wait indefinitely, error SHALL be constant 0, and no counter logic SHALL exist.

Verification (CLKDIV=4, DCM model answering progdone low 3 slots after GO, high 20 slots later, locked 50 cycles after that)
REQ-034: Scenario 1: cmd_m=0x0C, cmd_d=0x09 -> progdata sampled on progen-high progclk rises = 1,0,1,0,0,1,0,0,0,0 | 1,1,0,0,1,1,0,0,0,0 | 0; done pulses once; cmd_ready returns.
REQ-035: Scenario 2: cmd_valid held high through a transfer -> exactly one acceptance; second acceptance occurs only after done.
REQ-036: Scenario 3: sys_rst asserted in LOADM slot 4 -> next cycle all outputs 0, IDLE; a new command 0x01/0x01 completes normally.
REQ-037: Scenario 4 (TIMEOUT_EN, TIMEOUT=100): DCM never drops progdone -> error=1 after 100 cycles in WAITLO, no done, IDLE; next acceptance clears error.
REQ-038: Scenario 5: cmd_m=0xFF, cmd_d=0x00 -> M bits all 1, D bits all 0; progen low exactly 1 slot in each gap; progclk period = 4 cycles, 50% duty.
REQ-039: Scenario 6: vga_locked pulse narrower than 1 cycle or already high at WAITLOCK entry -> synchronized handling with no metastable propagation; done 3 cycles after a stable locked rise.
